// File: rtl/voice_bank.sv
// Purpose : time-multiplexed bank of NUM_VOICES oscillator+ADSR voices mixed into one sample.
// Latency : sample_tick accepted in cycle T -> out/out_valid in cycle T+NUM_VOICES+2.
// Backpr. : none; a sample_tick while busy is dropped and sets the sticky overrun flag.
//
// Ports:
//   sample_clock, rst      clock, asynchronous active-low reset
//   sample_tick            one-cycle request for a new mixed sample
//   cfg_we/voice/addr/data per-voice register write (increment, wave/gate, A, D, S, R)
//   out, out_valid         mixed sample (held) and its one-cycle update strobe
//   busy, overrun          walk in progress, sticky "tick while busy"
module voice_bank #(
  parameter int BITDEPTH    = 14,
  parameter int BITFRACTION = 6,
  parameter int NUM_VOICES  = 4,
  localparam int VB = $clog2(NUM_VOICES),
  localparam int PW = BITDEPTH + BITFRACTION
) (
  input  logic                sample_clock,
  input  logic                rst,
  input  logic                sample_tick,
  input  logic                cfg_we,
  input  logic [VB-1:0]       cfg_voice,
  input  logic [2:0]          cfg_addr,
  input  logic [15:0]         cfg_data,
  output logic [BITDEPTH-1:0] out,
  output logic                out_valid,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {S_IDLE, S_PROC, S_MIX} bank_state_t;
  typedef enum logic [2:0] {E_IDLE, E_ATTACK, E_DECAY, E_SUSTAIN, E_RELEASE} env_state_t;

  // Per-voice configuration
  logic [15:0] incr     [NUM_VOICES];
  logic [1:0]  wave_sel [NUM_VOICES];
  logic        gate     [NUM_VOICES];
  logic [7:0]  attack   [NUM_VOICES];
  logic [7:0]  decay    [NUM_VOICES];
  logic [7:0]  sustain  [NUM_VOICES];
  logic [7:0]  rel_rate [NUM_VOICES];

  // Per-voice running state
  logic [PW-1:0] phase  [NUM_VOICES];
  logic [7:0]    level  [NUM_VOICES];
  env_state_t    env_st [NUM_VOICES];

  bank_state_t          state;
  logic [VB-1:0]        idx;
  logic [BITDEPTH+VB-1:0] acc;
  logic [15:0]          lfsr;

  // Datapath for the voice in the current slot
  logic [PW-1:0]         phase_nxt;
  logic [BITDEPTH-1:0]   p;
  logic [BITDEPTH-1:0]   wave;
  logic [15:0]           lfsr_nxt;
  env_state_t            st_nxt;
  logic [7:0]            lvl_nxt;
  logic [8:0]            step;
  logic [9:0]            sum;
  logic [BITDEPTH+7:0]   prod;

  // A rate of 0 means a full-scale step so the target is hit in one tick.
  function automatic logic [8:0] rate_step(input logic [7:0] r);
    return (r == 8'd0) ? 9'd256 : {1'b0, r};
  endfunction

  always_comb begin
    phase_nxt = phase[idx] + PW'(incr[idx]);
    p         = phase_nxt[PW-1 -: BITDEPTH];
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    case (wave_sel[idx])
      2'd0:    wave = p;
      2'd1:    wave = phase_nxt[PW-1] ? '0 : '1;
      2'd2:    wave = phase_nxt[PW-1] ? {~p[BITDEPTH-2:0], 1'b0} : {p[BITDEPTH-2:0], 1'b0};
      default: wave = lfsr_nxt[15 -: BITDEPTH];
    endcase

    // Gate transitions first, then the resulting state's step in the same slot.
    st_nxt  = env_st[idx];
    lvl_nxt = level[idx];
    if (gate[idx] && (st_nxt == E_IDLE || st_nxt == E_RELEASE))
      st_nxt = E_ATTACK;
    else if (!gate[idx] && st_nxt != E_IDLE && st_nxt != E_RELEASE)
      st_nxt = E_RELEASE;

    step = '0;
    sum  = '0;
    case (st_nxt)
      E_ATTACK: begin
        step = rate_step(attack[idx]);
        sum  = {2'b00, lvl_nxt} + {1'b0, step};
        if (sum >= 10'd255) begin
          lvl_nxt = 8'd255;
          st_nxt  = E_DECAY;
        end else begin
          lvl_nxt = sum[7:0];
        end
      end
      E_DECAY: begin
        // level - step <= sustain, rearranged to stay unsigned
        step = rate_step(decay[idx]);
        sum  = {2'b00, sustain[idx]} + {1'b0, step};
        if ({2'b00, lvl_nxt} <= sum) begin
          lvl_nxt = sustain[idx];
          st_nxt  = E_SUSTAIN;
        end else begin
          lvl_nxt = lvl_nxt - step[7:0];
        end
      end
      E_RELEASE: begin
        step = rate_step(rel_rate[idx]);
        if ({1'b0, lvl_nxt} <= step) begin
          lvl_nxt = 8'd0;
          st_nxt  = E_IDLE;
        end else begin
          lvl_nxt = lvl_nxt - step[7:0];
        end
      end
      default: ;
    endcase

    prod = (BITDEPTH+8)'(wave) * (BITDEPTH+8)'(lvl_nxt);
  end

  always_ff @(posedge sample_clock or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        incr[v]     <= '0;
        wave_sel[v] <= '0;
        gate[v]     <= 1'b0;
        attack[v]   <= '0;
        decay[v]    <= '0;
        sustain[v]  <= '0;
        rel_rate[v] <= '0;
        phase[v]    <= '0;
        level[v]    <= '0;
        env_st[v]   <= E_IDLE;
      end
      state     <= S_IDLE;
      idx       <= '0;
      acc       <= '0;
      lfsr      <= 16'hACE1;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;

      // The walk reads the old values, so a same-slot write lands on the next tick.
      if (cfg_we) begin
        case (cfg_addr)
          3'd0: incr[cfg_voice] <= cfg_data;
          3'd1: begin
            wave_sel[cfg_voice] <= cfg_data[1:0];
            gate[cfg_voice]     <= cfg_data[8];
          end
          3'd2: attack[cfg_voice]   <= cfg_data[7:0];
          3'd3: decay[cfg_voice]    <= cfg_data[7:0];
          3'd4: sustain[cfg_voice]  <= cfg_data[7:0];
          3'd5: rel_rate[cfg_voice] <= cfg_data[7:0];
          default: ;
        endcase
      end

      if (sample_tick && busy)
        overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (sample_tick) begin
            state <= S_PROC;
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
          end
        end
        S_PROC: begin
          phase[idx]  <= phase_nxt;
          level[idx]  <= lvl_nxt;
          env_st[idx] <= st_nxt;
          if (wave_sel[idx] == 2'd3)
            lfsr <= lfsr_nxt;
          acc <= acc + (BITDEPTH+VB)'(prod >> 8);
          idx <= idx + 1'b1;
          if (idx == VB'(NUM_VOICES-1))
            state <= S_MIX;
        end
        S_MIX: begin
          out       <= acc[BITDEPTH+VB-1 -: BITDEPTH];
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
